// File: rtl/disc_pkg.sv
// Shared definitions for the discriminator layer-3 feeder: default element
// width, frame length, the feeder state encoding and a counter-width helper.
package disc_pkg;

  localparam int DATA_W = 16;
  localparam int N_IN   = 32;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disc_watchdog.sv
// WAIT-state watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT_CYC-th enabled cycle. Only built with DISC_L3_FEEDER_TIMEOUT_EN.
module disc_watchdog
  import disc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST_CYC = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cyc_cnt;

  // Count enabled cycles; restart from zero whenever the feeder leaves WAIT
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cyc_cnt <= '0;
    end else if (!expired) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  assign expired = enable && (cyc_cnt == LAST_CYC);

endmodule

// File: rtl/disc_l3_feeder.sv
// Collects N_IN signed Q8.8 elements into a packed frame, fires discriminator
// layer 3 with a one-cycle start pulse, waits for its done, and holds the
// captured score/decision until downstream accepts it.
// Optional feature: define DISC_L3_FEEDER_TIMEOUT_EN to add a WAIT watchdog
// that produces a zero-score result with timeout_err set after TIMEOUT_CYC.
module disc_l3_feeder #(
  parameter int DATA_W      = disc_pkg::DATA_W,
  parameter int N_IN        = disc_pkg::N_IN,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   l3_start,
  output logic [DATA_W*N_IN-1:0] l3_flat_input,
  input  logic [DATA_W-1:0]      l3_score,
  input  logic                   l3_decision,
  input  logic                   l3_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_score,
  output logic                   res_decision,
  output logic                   busy,
  output logic                   timeout_err
);

  import disc_pkg::*;

  localparam int CNT_W = cnt_width(N_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  // A zero-cycle watchdog limit would make WAIT meaningless
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("disc_l3_feeder: TIMEOUT_CYC must be at least 1");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef DISC_L3_FEEDER_TIMEOUT_EN
  logic wd_expired;

  disc_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state == WAIT),
    .expired(wd_expired)
  );
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready = (state == FILL);
  assign busy     = (state != FILL);

  // Frame assembly, layer-3 handshake and result hold in one registered FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      cnt           <= '0;
      l3_flat_input <= '0;
      l3_start      <= 1'b0;
      res_valid     <= 1'b0;
      res_score     <= '0;
      res_decision  <= 1'b0;
`ifdef DISC_L3_FEEDER_TIMEOUT_EN
      timeout_err   <= 1'b0;
`endif
    end else begin
      l3_start <= 1'b0;
      unique case (state)
        FILL: begin
          if (in_valid) begin
            l3_flat_input[cnt*DATA_W +: DATA_W] <= in_data;
            if (cnt == CNT_LAST) begin
              cnt      <= '0;
              l3_start <= 1'b1;
              state    <= FIRE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FIRE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (l3_done) begin
            res_score    <= l3_score;
            res_decision <= l3_decision;
            res_valid    <= 1'b1;
            state        <= HOLD;
`ifdef DISC_L3_FEEDER_TIMEOUT_EN
            timeout_err  <= 1'b0;
          end else if (wd_expired) begin
            res_score    <= '0;
            res_decision <= 1'b0;
            res_valid    <= 1'b1;
            timeout_err  <= 1'b1;
            state        <= HOLD;
`endif
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_disc_l3_feeder.sv
// Self-checking bench for disc_l3_feeder: a table of whole-frame vectors
// (element pattern, layer-3 stub behaviour, expected result) plus hand-written
// sequences for reset/abandon behaviour. With DISC_L3_FEEDER_TIMEOUT_EN defined
// the watchdog vectors are added.
module tb_disc_l3_feeder;

  localparam int DATA_W      = 16;
  localparam int N_IN        = 32;
  localparam int TIMEOUT_CYC = 64;
  localparam int BUS_W       = DATA_W * N_IN;

  typedef struct {
    logic [DATA_W-1:0] step;
    bit                useGaps;
    int                doneDelay;
    logic [DATA_W-1:0] score;
    logic              decision;
    int                holdCycles;
    int                expLatency;
    logic [DATA_W-1:0] expScore;
    logic              expDecision;
    logic              expTimeout;
  } frameVec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              l3_start;
  logic [BUS_W-1:0]  l3_flat_input;
  logic [DATA_W-1:0] l3_score = '0;
  logic              l3_decision = 1'b0;
  logic              l3_done = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_score;
  logic              res_decision;
  logic              busy;
  logic              timeout_err;

  int compareCount  = 0;
  int mismatchCount = 0;
  int startCount    = 0;

  frameVec_t frames[4];
`ifdef DISC_L3_FEEDER_TIMEOUT_EN
  frameVec_t toFrames[2];
`endif

  disc_l3_feeder #(
    .DATA_W     (DATA_W),
    .N_IN       (N_IN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .l3_start     (l3_start),
    .l3_flat_input(l3_flat_input),
    .l3_score     (l3_score),
    .l3_decision  (l3_decision),
    .l3_done      (l3_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_score    (res_score),
    .res_decision (res_decision),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Count start pulses seen away from the active edge
  always @(negedge clk) begin
    if (rst_n && l3_start === 1'b1) startCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [BUS_W-1:0] actual,
                             input logic [BUS_W-1:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_l3_start"}, l3_start, 0);
    checkOutput({tag, "_res_valid"}, res_valid, 0);
    checkOutput({tag, "_res_score"}, res_score, 0);
    checkOutput({tag, "_res_decision"}, res_decision, 0);
    checkOutput({tag, "_timeout_err"}, timeout_err, 0);
    checkOutput({tag, "_flat_input"}, l3_flat_input, 0);
  endtask

  // Feed one frame, emulate layer 3, then drain the result through HOLD
  task automatic applyStimulus(input frameVec_t v, input string tag);
    logic [BUS_W-1:0]  expBus;
    logic [DATA_W-1:0] elem;
    int                startsBefore;
    int                cyc;
    int                gap;
    bit                busStable;
    bit                holdOk;
    expBus       = '0;
    startsBefore = startCount;
    for (int k = 0; k < N_IN; k++) begin
      if (v.useGaps) begin
        gap      = $urandom_range(0, 3);
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      elem                          = DATA_W'(k * v.step);
      in_valid                      = 1'b1;
      in_data                       = elem;
      expBus[k*DATA_W +: DATA_W]    = elem;
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    checkOutput({tag, "_start_after_last_beat"}, l3_start, 1);
    checkOutput({tag, "_frame_bus"}, l3_flat_input, expBus);
    cyc       = 1;
    busStable = 1'b1;
    while (res_valid !== 1'b1 && cyc < 200) begin
      l3_done     = (v.doneDelay != 0) && (cyc == 1 + v.doneDelay);
      l3_score    = l3_done ? v.score : 16'hDEAD;
      l3_decision = l3_done ? v.decision : ~v.decision;
      tick();
      cyc++;
      if (res_valid !== 1'b1 && l3_flat_input !== expBus) busStable = 1'b0;
    end
    l3_done = 1'b0;
    checkOutput({tag, "_bus_const_in_wait"}, busStable, 1);
    checkOutput({tag, "_latency"}, cyc, v.expLatency);
    checkOutput({tag, "_res_valid"}, res_valid, 1);
    checkOutput({tag, "_res_score"}, res_score, v.expScore);
    checkOutput({tag, "_res_decision"}, res_decision, v.expDecision);
    checkOutput({tag, "_timeout_err"}, timeout_err, v.expTimeout);
    checkOutput({tag, "_busy_in_hold"}, busy, 1);
    checkOutput({tag, "_start_count"}, startCount - startsBefore, 1);
    holdOk    = 1'b1;
    res_ready = 1'b0;
    repeat (v.holdCycles) begin
      tick();
      if (res_valid !== 1'b1 || res_score !== v.expScore || res_decision !== v.expDecision ||
          in_ready !== 1'b0 || busy !== 1'b1)
        holdOk = 1'b0;
    end
    if (v.holdCycles > 0) checkOutput({tag, "_hold_stable"}, holdOk, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput({tag, "_fill_after_ready"}, in_ready, 1);
    checkOutput({tag, "_res_valid_cleared"}, res_valid, 0);
  endtask

  initial begin
    // step, gaps, doneDelay, score, dec, hold, latency, expScore, expDec, expTimeout
    frames[0] = '{16'h0000, 1'b0, 8, 16'h0180, 1'b1, 0, 10, 16'h0180, 1'b1, 1'b0};
    frames[1] = '{16'h0010, 1'b1, 8, 16'hFF80, 1'b0, 5, 10, 16'hFF80, 1'b0, 1'b0};
    frames[2] = '{16'h0101, 1'b1, 3, 16'h7FFF, 1'b1, 1, 5, 16'h7FFF, 1'b1, 1'b0};
    frames[3] = '{16'hFFF0, 1'b0, 1, 16'h8000, 1'b0, 0, 3, 16'h8000, 1'b0, 1'b0};
`ifdef DISC_L3_FEEDER_TIMEOUT_EN
    toFrames[0] = '{16'h0003, 1'b0, 0, 16'h0000, 1'b0, 0, 66, 16'h0000, 1'b0, 1'b1};
    toFrames[1] = '{16'h0003, 1'b0, 64, 16'h0123, 1'b1, 0, 66, 16'h0123, 1'b1, 1'b0};
`endif

    rst_n = 1'b0;
    tick();
    tick();
    checkIdle("reset");
    rst_n = 1'b1;
    tick();

    // A done while filling must be ignored
    l3_done     = 1'b1;
    l3_score    = 16'h1234;
    l3_decision = 1'b1;
    tick();
    l3_done = 1'b0;
    tick();
    checkOutput("done_in_fill_busy", busy, 0);
    checkOutput("done_in_fill_res_valid", res_valid, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(frames[i], $sformatf("vec%0d", i));
    end

    // Abandon a frame by resetting in the middle of WAIT
    for (int k = 0; k < N_IN; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    checkOutput("mid_wait_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkIdle("abandon");
    l3_done     = 1'b1;
    l3_score    = 16'h0555;
    l3_decision = 1'b1;
    tick();
    l3_done = 1'b0;
    repeat (10) tick();
    checkOutput("late_done_res_valid", res_valid, 0);
    checkOutput("late_done_busy", busy, 0);
    applyStimulus(frames[0], "fresh");

`ifdef DISC_L3_FEEDER_TIMEOUT_EN
    applyStimulus(toFrames[0], "timeout");
    applyStimulus(toFrames[1], "coincident");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
